// File: rtl/digest_readout_ctrl.sv
// Digest readout controller.
// Captures a finished hash digest into the output buffer once, then walks
// the words 1..NWORDS out to a valid/ready consumer, one word at a time.
module digest_readout_ctrl #(
    parameter int NWORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hash_done,
    input  logic        abort,
    output logic        buf_en,
    output logic [3:0]  buf_addr,
    input  logic [31:0] buf_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        overrun
);

    localparam logic [3:0] NW = 4'(NWORDS);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        FETCH,
        LOAD,
        SEND
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic       xfer;

    assign xfer = out_valid && out_ready;

    // Readout sequencer; every output is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 4'd1;
            buf_en    <= 1'b0;
            buf_addr  <= 4'd0;
            out_data  <= 32'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A new digest while one is in flight is dropped but remembered.
            if (hash_done && state != IDLE)
                overrun <= 1'b1;

            if (abort) begin
                // Cancel wins over everything, including a same-cycle transfer.
                state     <= IDLE;
                idx       <= 4'd1;
                buf_en    <= 1'b0;
                buf_addr  <= 4'd0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (hash_done) begin
                            state   <= CAPTURE;
                            idx     <= 4'd1;
                            overrun <= 1'b0;
                            buf_en  <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        // Single capture pulse: later hash_done cannot touch the buffer.
                        state    <= FETCH;
                        buf_en   <= 1'b0;
                        buf_addr <= idx;
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        // buf_data now reflects buf_addr from the FETCH edge.
                        state     <= SEND;
                        out_data  <= buf_data;
                        out_valid <= 1'b1;
                        out_last  <= (idx == NW);
                    end
                    SEND: begin
                        if (xfer) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (idx == NW) begin
                                state    <= IDLE;
                                idx      <= 4'd1;
                                buf_addr <= 4'd0;
                                busy     <= 1'b0;
                            end else begin
                                state    <= FETCH;
                                idx      <= idx + 4'd1;
                                buf_addr <= idx + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        idx       <= 4'd1;
                        buf_en    <= 1'b0;
                        buf_addr  <= 4'd0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digest_readout_ctrl.sv
// Bench for digest_readout_ctrl: an 8-word and a 4-word instance, each with
// a small output-buffer model; expected words come from the captured digest.
module tb_digest_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hash_done = 1'b0, hash_done4 = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;

    logic        buf_en8, buf_en4, v8, v4, l8, l4, busy8, busy4, ovr8, ovr4;
    logic [3:0]  addr8, addr4;
    logic [31:0] bd8, bd4, d8, d4;

    logic [31:0] digest_in [8];
    logic [31:0] exp_w [8];
    logic [31:0] store8 [16];
    logic [31:0] store4 [16];

    int passes = 0, checks = 0, cyc = 0;
    int en_cnt8 = 0, en_cnt4 = 0;
    bit sel = 1'b0;

    logic        obs_valid, obs_last, obs_busy, obs_en;
    logic [3:0]  obs_addr;
    logic [31:0] obs_data;

    always #5 clk = ~clk;

    digest_readout_ctrl #(.NWORDS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .hash_done(hash_done), .abort(abort),
        .buf_en(buf_en8), .buf_addr(addr8), .buf_data(bd8), .out_data(d8),
        .out_valid(v8), .out_ready(out_ready), .out_last(l8), .busy(busy8),
        .overrun(ovr8));

    digest_readout_ctrl #(.NWORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .hash_done(hash_done4), .abort(abort),
        .buf_en(buf_en4), .buf_addr(addr4), .buf_data(bd4), .out_data(d4),
        .out_valid(v4), .out_ready(out_ready), .out_last(l4), .busy(busy4),
        .overrun(ovr4));

    assign obs_valid = sel ? v4 : v8;
    assign obs_last  = sel ? l4 : l8;
    assign obs_busy  = sel ? busy4 : busy8;
    assign obs_en    = sel ? buf_en4 : buf_en8;
    assign obs_addr  = sel ? addr4 : addr8;
    assign obs_data  = sel ? d4 : d8;

    // Output buffer models: latch the digest on buf_en, registered word read.
    initial for (int i = 0; i < 16; i++) begin store8[i] = 0; store4[i] = 0; end
    always @(posedge clk) begin
        if (buf_en8) for (int i = 0; i < 8; i++) store8[i+1] <= digest_in[i];
        if (buf_en4) for (int i = 0; i < 8; i++) store4[i+1] <= digest_in[i];
        bd8 <= store8[addr8];
        bd4 <= store4[addr4];
        if (buf_en8) en_cnt8 <= en_cnt8 + 1;
        if (buf_en4) en_cnt4 <= en_cnt4 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic new_digest();
        for (int i = 0; i < 8; i++) digest_in[i] = $urandom;
    endtask

    // Pulse hash_done on the selected instance; afterwards cyc==1 (CAPTURE).
    task automatic start();
        for (int i = 0; i < 8; i++) exp_w[i] = digest_in[i];
        if (sel) hash_done4 = 1'b1; else hash_done = 1'b1;
        cyc = 0;
        tick();
        hash_done = 1'b0; hash_done4 = 1'b0;
        chk("start_busy", 32'(obs_busy), 32'd1);
        chk("start_buf_en", 32'(obs_en), 32'd1);
    endtask

    // Consume nw words, checking order, timing, out_last and buf_addr.
    task automatic readout(input int nw, input int np, input int stall_w, input int stall_len,
                           input bit rnd, input int hash_w, input int abort_w);
        int w = 0, budget = 500, stall = 0, next_cyc = 4;
        bit seen = 0, hashed = 0, rdy;
        while (w < nw && budget > 0) begin
            if (obs_valid) begin
                if (!seen) begin chk("latency", 32'(cyc), 32'(next_cyc)); seen = 1; end
                chk("data", obs_data, exp_w[w]);
                chk("last", 32'(obs_last), 32'(w == np - 1));
                chk("addr", 32'(obs_addr), 32'(w + 1));
                if (w == abort_w) begin
                    abort = 1'b1; out_ready = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk("abort_valid", 32'(obs_valid), 32'd0);
                    chk("abort_busy", 32'(obs_busy), 32'd0);
                    return;
                end
                if (w == hash_w && !hashed) begin
                    hash_done = 1'b1; new_digest(); hashed = 1;
                end
                if (w == stall_w && stall < stall_len) begin rdy = 0; stall++; end
                else rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                out_ready = rdy;
                if (rdy) begin w++; seen = 0; next_cyc = cyc + 3; end
            end else begin
                chk("last_idle", 32'(obs_last), 32'd0);
            end
            tick();
            hash_done = 1'b0;
            budget--;
        end
        if (w < nw) chk("timeout_words", 32'(w), 32'(nw));
    endtask

    initial begin
        int en0;
        // Reset values
        #2;
        chk("rst_buf_en", 32'(buf_en8), 32'd0);
        chk("rst_addr", 32'(addr8), 32'd0);
        chk("rst_data", d8, 32'd0);
        chk("rst_valid", 32'(v8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_overrun", 32'(ovr8), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Full readout with the SHA-256 IV as digest, ready tied high
        digest_in = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        en0 = en_cnt8;
        start();
        readout(8, 8, -1, 0, 0, -1, -1);
        chk("full_busy_after", 32'(busy8), 32'd0);
        chk("full_valid_after", 32'(v8), 32'd0);
        chk("full_data_kept", d8, 32'h5be0cd19);
        chk("full_en_pulses", 32'(en_cnt8 - en0), 32'd1);

        // Backpressure on word C for 5 cycles
        new_digest();
        start();
        readout(8, 8, 2, 5, 0, -1, -1);

        // Second hash_done during word D with a fresh digest on the inputs
        new_digest();
        en0 = en_cnt8;
        start();
        readout(8, 8, -1, 0, 0, 3, -1);
        chk("ovr_flag", 32'(ovr8), 32'd1);
        chk("ovr_en_pulses", 32'(en_cnt8 - en0), 32'd1);

        // Abort while word B is offered and accepted; then restart at A
        new_digest();
        start();
        chk("ovr_cleared", 32'(ovr8), 32'd0);
        readout(8, 8, -1, 0, 0, -1, 1);
        start();
        readout(8, 8, -1, 0, 0, -1, -1);
        chk("restart_idle", 32'(busy8), 32'd0);

        // Randomized backpressure
        for (int r = 0; r < 3; r++) begin
            new_digest();
            start();
            readout(8, 8, -1, 0, 1, -1, -1);
        end
        out_ready = 1'b1;

        // Async reset during LOAD of word F
        new_digest();
        start();
        readout(5, 8, -1, 0, 0, -1, -1);
        tick();
        chk("loadF_addr", 32'(addr8), 32'd6);
        chk("loadF_valid", 32'(v8), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {buf_en8, addr8, v8, l8, busy8, ovr8}, 32'd0);
        chk("mid_rst_data", d8, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // NWORDS=4 instance after release: A..D with out_last on D
        sel = 1'b1;
        new_digest();
        start();
        readout(4, 4, -1, 0, 0, -1, -1);
        chk("n4_busy_after", 32'(busy4), 32'd0);
        chk("n4_data_kept", d4, exp_w[3]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/digest_readout_ctrl.md
DIGEST_READOUT_CTRL -- requirements
Module: digest_readout_ctrl

Interface
REQ-001 Parameter NWORDS, default 8, number of 32-bit digest words read out per hash; legal range 1..8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 hash_done  input  1  one-cycle pulse: digest words valid on output-buffer inputs this cycle.
REQ-005 abort  input  1  synchronous cancel of the current readout.
REQ-006 buf_en  output  1  capture enable to output buffer.
REQ-007 buf_addr  output  4  word select to output buffer; 1..8 = word A..H, 0 = none.
REQ-008 buf_data  input  32  registered word from output buffer; reflects buf_addr sampled at the previous edge.
REQ-009 out_data  output  32  digest word presented to consumer.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_ready  input  1  consumer accepts; transfer when out_valid and out_ready are both 1 at an edge.
REQ-012 out_last  output  1  high with out_valid on word NWORDS only.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 overrun  output  1  sticky: hash_done arrived while busy.

Function
REQ-015 FSM states SHALL be IDLE, CAPTURE, FETCH, LOAD, SEND; a word index idx counts 1..NWORDS.
REQ-016 IDLE: buf_en=0, buf_addr=0, out_valid=0; on hash_done=1 (and abort=0) -> CAPTURE, idx<=1, overrun<=0.
REQ-017 CAPTURE: buf_en=1 for exactly this one cycle -> FETCH.
REQ-018 FETCH: buf_addr=idx -> LOAD.
REQ-019 LOAD: buf_addr held at idx; out_data<=buf_data at the closing edge -> SEND.
REQ-020 SEND: out_valid=1, out_data and out_last stable until transfer; buf_addr held at idx.
REQ-021 SEND with transfer and idx<NWORDS -> FETCH, idx<=idx+1; with idx=NWORDS -> IDLE.
REQ-022 Latency: hash_done sampled at edge 0 -> out_valid=1 from cycle 4; each subsequent word 3 cycles after the previous transfer, stalling indefinitely while out_ready=0.
REQ-023 buf_en SHALL assert only in CAPTURE; digest is captured once per readout, so later hash_done cannot corrupt words in flight.
REQ-024 hash_done in any state other than IDLE SHALL be ignored and SHALL set overrun=1.
REQ-025 abort=1 in any state -> IDLE at next edge, out_valid=0, idx<=1; abort beats a simultaneous transfer (word counted as not sent) and beats a simultaneous hash_done in IDLE.
REQ-026 out_data SHALL keep its last value after leaving SEND; only out_valid qualifies it.
REQ-027 out_last SHALL equal (state==SEND && idx==NWORDS).

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, idx=1, buf_en=0, buf_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, overrun=0, including mid-readout.
REQ-029 First hash_done honoured SHALL be the one sampled at the first edge after rst_n deasserts.

Verification
REQ-030 Full readout, out_ready tied 1, digest A..H = 0x6a09e667..0x5be0cd19 -> eight transfers in order A..H, out_valid at cycles 4,7,...,25, out_last only on H, busy falls after H.
REQ-031 Backpressure: out_ready=0 for 5 cycles on word C -> out_data=word C held stable, buf_addr=3 held, no skipped/duplicated word.
REQ-032 hash_done pulsed again during word D with new digest inputs -> overrun=1, remaining words E..H are original digest values, no buf_en pulse.
REQ-033 abort in SEND with out_ready=1 on word B -> no B transfer counted, IDLE next cycle, next hash_done restarts at word A and clears overrun.
REQ-034 rst_n dropped during LOAD of word F -> all outputs at reset values same cycle; after release, readout with NWORDS=4 yields A..D with out_last on D.
